key_value_setter: RTL and testbench

//  Produces the 0..MAX_VAL binary value shown on a two-digit seven-segment pair.
//  Two raw active-low pushbuttons step the value up or down, with auto-repeat on hold.

---
 rtl/key_value_setter.sv | 142 ++++++++++++++
 tb/tb_key_value_setter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/key_value_setter.sv
// Up/down value setter for a two-digit display: synchronised, debounced keys
// drive a step FSM with hold-to-repeat, plus a clamped parallel load.
module key_value_setter #(
    parameter int WIDTH        = 6,
    parameter int MAX_VAL      = 59,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DLY   = 25000000,
    parameter int REPEAT_PER   = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_inc_n,
    input  logic             key_dec_n,
    input  logic             set_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             step_pulse
);
    localparam int TW = $clog2((REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER) + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    // Key vectors are indexed [0]=inc, [1]=dec; 1 means released.
    logic [1:0]    raw_n;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d;
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           dir_q, dir_d;
    logic           armed_q, armed_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic           step_pulse_q, step_pulse_d;

    logic inc, dec, key_any, step;
    logic [TW-1:0] limit;

    assign raw_n = {key_dec_n, key_inc_n};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]  = deb_q[i];
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYC - 1))
                    deb_d[i] = sync2_q[i];
                else
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    assign inc     = ~deb_q[0] &  deb_q[1];
    assign dec     =  deb_q[0] & ~deb_q[1];
    assign key_any = inc | dec;
    assign limit   = (state_q == DELAY) ? TW'(REPEAT_DLY - 1) : TW'(REPEAT_PER - 1);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        dir_d        = dir_q;
        armed_d      = armed_q;
        value_d      = value_q;
        step_pulse_d = 1'b0;
        step         = 1'b0;
        case (state_q)
            IDLE: begin
                // A new press is honoured only after the keys were seen idle.
                if (!key_any) begin
                    armed_d = 1'b1;
                end else if (set_en && armed_q) begin
                    step    = 1'b1;
                    dir_d   = inc;
                    armed_d = 1'b0;
                    state_d = DELAY;
                    timer_d = '0;
                end
            end
            DELAY, REPEAT: begin
                if (!set_en || !key_any || (inc != dir_q)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == limit) begin
                    step    = 1'b1;
                    state_d = REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        if (load) begin
            value_d = (load_value > WIDTH'(MAX_VAL)) ? WIDTH'(MAX_VAL) : load_value;
        end else if (step) begin
            step_pulse_d = 1'b1;
            if (dir_d)
                value_d = (value_q == WIDTH'(MAX_VAL)) ? '0 : value_q + 1'b1;
            else
                value_d = (value_q == '0) ? WIDTH'(MAX_VAL) : value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            deb_q        <= '1;
            dcnt_q[0]    <= '0;
            dcnt_q[1]    <= '0;
            state_q      <= IDLE;
            timer_q      <= '0;
            dir_q        <= 1'b0;
            armed_q      <= 1'b1;
            value_q      <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= raw_n;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            dcnt_q[0]    <= dcnt_d[0];
            dcnt_q[1]    <= dcnt_d[1];
            state_q      <= state_d;
            timer_q      <= timer_d;
            dir_q        <= dir_d;
            armed_q      <= armed_d;
            value_q      <= value_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign value      = value_q;
    assign step_pulse = step_pulse_q;
endmodule

// File: tb/tb_key_value_setter.sv
// Directed bench for key_value_setter with short debounce/repeat timing.
module tb_key_value_setter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_inc_n = 1'b1;
    logic       key_dec_n = 1'b1;
    logic       set_en = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_value = '0;
    logic [5:0] value;
    logic       step_pulse;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int npulse = 0;
    int pulse_cyc[$];
    int pulse_val[$];

    key_value_setter #(
        .WIDTH(6), .MAX_VAL(59), .DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_PER(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .set_en(set_en), .load(load), .load_value(load_value),
        .value(value), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            npulse++;
            pulse_cyc.push_back(cyc);
            pulse_val.push_back(int'(value));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_log();
        npulse = 0;
        pulse_cyc.delete();
        pulse_val.delete();
    endtask

    task automatic do_load(input logic [5:0] v);
        load = 1'b1; load_value = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (value !== 6'd0) begin fails++; $display("FAIL reset_value got %0d want 0", value); end
        tests++; if (step_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse got %b want 0", step_pulse); end
        rst_n = 1'b1; set_en = 1'b1;
        idle(3);
    endtask

    task automatic test_bounce();
        clr_log();
        key_inc_n = 1'b0; idle(2); key_inc_n = 1'b1;
        idle(12);
        tests++; if (value !== 6'd0) begin fails++; $display("FAIL bounce_value got %0d want 0", value); end
        tests++; if (npulse != 0) begin fails++; $display("FAIL bounce_pulses got %0d want 0", npulse); end
    endtask

    task automatic test_single_step();
        clr_log();
        key_inc_n = 1'b0; idle(10); key_inc_n = 1'b1;
        idle(12);
        tests++; if (value !== 6'd1) begin fails++; $display("FAIL single_value got %0d want 1", value); end
        tests++; if (npulse != 1) begin fails++; $display("FAIL single_pulses got %0d want 1", npulse); end
    endtask

    task automatic test_repeat_wrap();
        do_load(6'd58);
        tests++; if (value !== 6'd58) begin fails++; $display("FAIL load58 got %0d want 58", value); end
        clr_log();
        key_inc_n = 1'b0; idle(40); key_inc_n = 1'b1;
        idle(12);
        tests++; if (npulse != 5) begin fails++; $display("FAIL repeat_pulses got %0d want 5", npulse); end
        tests++; if (value !== 6'd3) begin fails++; $display("FAIL repeat_final got %0d want 3", value); end
        tests++;
        if (pulse_val.size() >= 3) begin
            if (pulse_val[0] != 59 || pulse_val[1] != 0 || pulse_val[2] != 1) begin
                fails++;
                $display("FAIL repeat_seq got %0d,%0d,%0d want 59,0,1", pulse_val[0], pulse_val[1], pulse_val[2]);
            end
        end else begin
            fails++; $display("FAIL repeat_seq got %0d pulses want >=3", pulse_val.size());
        end
        tests++;
        if (pulse_cyc.size() >= 3) begin
            if (pulse_cyc[1] - pulse_cyc[0] != 20 || pulse_cyc[2] - pulse_cyc[1] != 5) begin
                fails++;
                $display("FAIL repeat_gaps got %0d,%0d want 20,5", pulse_cyc[1] - pulse_cyc[0], pulse_cyc[2] - pulse_cyc[1]);
            end
        end else begin
            fails++; $display("FAIL repeat_gaps got %0d pulses want >=3", pulse_cyc.size());
        end
    endtask

    task automatic test_dec_and_both();
        do_load(6'd0);
        clr_log();
        key_dec_n = 1'b0; idle(8); key_dec_n = 1'b1;
        idle(12);
        tests++; if (value !== 6'd59) begin fails++; $display("FAIL dec_wrap got %0d want 59", value); end
        tests++; if (npulse != 1) begin fails++; $display("FAIL dec_pulses got %0d want 1", npulse); end
        clr_log();
        key_inc_n = 1'b0; key_dec_n = 1'b0; idle(30);
        key_inc_n = 1'b1; key_dec_n = 1'b1; idle(12);
        tests++; if (value !== 6'd59) begin fails++; $display("FAIL both_value got %0d want 59", value); end
        tests++; if (npulse != 0) begin fails++; $display("FAIL both_pulses got %0d want 0", npulse); end
    endtask

    task automatic test_load_priority();
        clr_log();
        key_inc_n = 1'b0;
        idle(6);
        // Load lands on the same edge as the first step.
        load = 1'b1; load_value = 6'd10;
        @(negedge clk);
        load = 1'b0;
        tests++; if (value !== 6'd10) begin fails++; $display("FAIL load_prio_value got %0d want 10", value); end
        tests++; if (npulse != 0) begin fails++; $display("FAIL load_prio_pulse got %0d want 0", npulse); end
        idle(20);
        tests++; if (value !== 6'd11) begin fails++; $display("FAIL load_fsm_kept got %0d want 11", value); end
        key_inc_n = 1'b1;
        idle(12);
        tests++; if (value !== 6'd12) begin fails++; $display("FAIL load_after_rel got %0d want 12", value); end
        do_load(6'd63);
        tests++; if (value !== 6'd59) begin fails++; $display("FAIL load_clamp got %0d want 59", value); end
        tests++; if (step_pulse !== 1'b0) begin fails++; $display("FAIL load_clamp_pulse got %b want 0", step_pulse); end
    endtask

    task automatic test_reset_in_repeat();
        do_load(6'd5);
        key_inc_n = 1'b0;
        idle(30);
        tests++; if (value !== 6'd7) begin fails++; $display("FAIL pre_reset got %0d want 7", value); end
        rst_n = 1'b0;
        #1;
        tests++; if (value !== 6'd0) begin fails++; $display("FAIL async_reset_value got %0d want 0", value); end
        tests++; if (step_pulse !== 1'b0) begin fails++; $display("FAIL async_reset_pulse got %b want 0", step_pulse); end
        key_inc_n = 1'b1;
        idle(3);
        rst_n = 1'b1;
        clr_log();
        idle(15);
        tests++; if (value !== 6'd0) begin fails++; $display("FAIL post_reset_hold got %0d want 0", value); end
        tests++; if (npulse != 0) begin fails++; $display("FAIL post_reset_pulses got %0d want 0", npulse); end
        key_inc_n = 1'b0; idle(10); key_inc_n = 1'b1;
        idle(12);
        tests++; if (value !== 6'd1) begin fails++; $display("FAIL repress_value got %0d want 1", value); end
    endtask

    task automatic test_set_en_off();
        set_en = 1'b0;
        clr_log();
        key_dec_n = 1'b0; idle(10); key_dec_n = 1'b1;
        idle(12);
        tests++; if (value !== 6'd1) begin fails++; $display("FAIL set_en_off_value got %0d want 1", value); end
        tests++; if (npulse != 0) begin fails++; $display("FAIL set_en_off_pulses got %0d want 0", npulse); end
        set_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_single_step();
        test_repeat_wrap();
        idle(5);
        test_dec_and_both();
        test_load_priority();
        idle(5);
        test_reset_in_repeat();
        test_set_en_off();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
